riscv_pipe_ctrl: RTL and testbench

//  Pipeline control unit for the pipelined RISC-V core. It drives the enable
//  and flush (bubble-insert) inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB

---
 rtl/riscv_pipe_ctrl.sv | 120 ++++++++++++
 tb/tb_riscv_pipe_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/riscv_pipe_ctrl.sv
// Pipeline control for the pipelined RISC-V core: register enables and bubble
// inserts for load-use, taken branches, multi-cycle mul/div and dmem waits.
module riscv_pipe_ctrl #(
   parameter int DLY_FF     = 1,
   parameter int MD_LATENCY = 8,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_rs1_used,
   input  logic                  id_rs2_used,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_mem_read,
   input  logic                  ex_md_start,
   input  logic                  ex_branch_taken,
   input  logic                  mem_req,
   input  logic                  mem_ready,
   output logic                  pc_en,
   output logic                  if_id_en,
   output logic                  id_ex_en,
   output logic                  ex_mem_en,
   output logic                  mem_wb_en,
   output logic                  if_id_flush,
   output logic                  id_ex_flush,
   output logic                  ex_mem_flush,
   output logic                  md_busy,
   output logic [1:0]            ctrl_state
);

   // Flops carry no modelled delay, so DLY_FF only takes part in this check.
   if (MD_LATENCY < 2 || DLY_FF < 0) begin : g_param_check
      $error("riscv_pipe_ctrl: MD_LATENCY must be >= 2 and DLY_FF >= 0");
   end

   localparam int CNT_W = (MD_LATENCY > 2) ? $clog2(MD_LATENCY - 1) : 1;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      MD_BUSY  = 2'd2
   } state_t;

   // Control word: {pc, if_id, id_ex, ex_mem, mem_wb enables, if_id, id_ex, ex_mem flushes}
   localparam logic [7:0] CTRL_ALL  = 8'b11111_000;
   localparam logic [7:0] CTRL_LU   = 8'b00111_010;
   localparam logic [7:0] CTRL_BR   = 8'b11111_110;
   localparam logic [7:0] CTRL_MD   = 8'b00011_001;
   localparam logic [7:0] CTRL_STOP = 8'b00000_000;

   state_t           state, state_next;
   logic [CNT_W-1:0] md_cnt, md_cnt_next;
   logic [7:0]       ctrl;
   logic             mem_stall;
   logic             load_use;

   assign mem_stall = mem_req & ~mem_ready;
   assign load_use  = ex_mem_read && (ex_rd != '0) &&
                      ((id_rs1_used && (id_rs1 == ex_rd)) ||
                       (id_rs2_used && (id_rs2 == ex_rd)));

   function automatic logic [7:0] run_ctrl(input logic md, input logic br, input logic lu);
      if (md)      return CTRL_MD;
      else if (br) return CTRL_BR;
      else if (lu) return CTRL_LU;
      else         return CTRL_ALL;
   endfunction

   always_comb begin
      ctrl        = CTRL_STOP;
      state_next  = state;
      md_cnt_next = md_cnt;
      if (reset) begin
         case (state)
            RUN, MEM_WAIT: begin
               if (mem_stall) begin
                  state_next = MEM_WAIT;
               end else begin
                  ctrl       = run_ctrl(ex_md_start, ex_branch_taken, load_use);
                  state_next = RUN;
                  if (ex_md_start) begin
                     state_next  = MD_BUSY;
                     md_cnt_next = CNT_W'(MD_LATENCY - 2);
                  end
               end
            end
            MD_BUSY: begin
               // The occupancy counter keeps running even while dmem stalls.
               md_cnt_next = (md_cnt == '0) ? '0 : md_cnt - CNT_W'(1);
               if (mem_stall) begin
                  ctrl = CTRL_STOP;
               end else if (md_cnt != '0) begin
                  ctrl = CTRL_MD;
               end else begin
                  ctrl       = CTRL_ALL;
                  state_next = RUN;
               end
            end
            default: state_next = RUN;
         endcase
      end
   end

   assign {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush} = ctrl;
   assign md_busy    = reset && (state == MD_BUSY);
   assign ctrl_state = reset ? state : RUN;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= RUN;
         md_cnt <= '0;
      end else begin
         state  <= state_next;
         md_cnt <= md_cnt_next;
      end
   end

endmodule

// File: tb/tb_riscv_pipe_ctrl.sv
// Directed bench for riscv_pipe_ctrl: vector table for single-cycle RUN
// behaviour plus hand sequences for mul/div, dmem wait and reset corners.
module tb_riscv_pipe_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_rs1_used, id_rs2_used, ex_mem_read, ex_md_start;
   logic       ex_branch_taken, mem_req, mem_ready;
   logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic       if_id_flush, id_ex_flush, ex_mem_flush, md_busy;
   logic [1:0] ctrl_state;

   int n_vec = 0;
   int n_bad = 0;

   riscv_pipe_ctrl #(.DLY_FF(1), .MD_LATENCY(8), .REG_ADDR_W(5)) dut (
      .clk(clk), .reset(reset),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_md_start(ex_md_start),
      .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
      .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
      .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .ex_mem_flush(ex_mem_flush), .md_busy(md_busy), .ctrl_state(ctrl_state)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      assert (!(ex_md_start && ex_branch_taken))
         else $error("stimulus drives ex_md_start and ex_branch_taken together");

   // Expected word: {5 enables, 3 flushes, md_busy, ctrl_state}
   function automatic logic [10:0] mk(input logic [4:0] en, input logic [2:0] fl,
                                      input logic busy, input logic [1:0] st);
      return {en, fl, busy, st};
   endfunction

   localparam logic [10:0] E_ZERO = 11'b00000_000_0_00;
   localparam logic [10:0] E_ALL  = 11'b11111_000_0_00;
   localparam logic [10:0] E_LU   = 11'b00111_010_0_00;
   localparam logic [10:0] E_BR   = 11'b11111_110_0_00;
   localparam logic [10:0] E_MDE  = 11'b00011_001_0_00;
   localparam logic [10:0] E_HOLD = 11'b00011_001_1_10;
   localparam logic [10:0] E_REL  = 11'b11111_000_1_10;
   localparam logic [10:0] E_MDST = 11'b00000_000_1_10;

   typedef struct {
      string       name;
      logic [4:0]  rs1, rs2;
      logic        u1, u2;
      logic [4:0]  rd;
      logic        mr, md, br, req, rdy;
      logic [10:0] exp;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mkv(input string name, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic [4:0] rd,
                                input logic mr, input logic br, input logic req,
                                input logic rdy, input logic [10:0] exp);
      vec_t v;
      v.name = name; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
      v.mr = mr; v.md = 1'b0; v.br = br; v.req = req; v.rdy = rdy; v.exp = exp;
      return v;
   endfunction

   task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                        input logic u2, input logic [4:0] rd, input logic mr,
                        input logic md, input logic br, input logic req, input logic rdy);
      id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2; ex_rd = rd;
      ex_mem_read = mr; ex_md_start = md; ex_branch_taken = br;
      mem_req = req; mem_ready = rdy;
   endtask

   task automatic idle();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   // Inputs are already applied; compare mid-cycle, then advance past the next edge.
   task automatic cyc(input string name, input logic [10:0] exp);
      logic [10:0] got;
      @(negedge clk);
      got = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
             if_id_flush, id_ex_flush, ex_mem_flush, md_busy, ctrl_state};
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b required %b (en5_fl3_busy_st2)", name, got, exp);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic md_entry();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      cyc("md_entry", E_MDE);
      idle();
   endtask

   initial begin
      logic md_r;
      reset = 1'b0;
      idle();
      #1;

      // Reset with random inputs
      for (int i = 0; i < 3; i++) begin
         md_r = 1'($urandom);
         drive(5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
               1'($urandom), md_r, 1'($urandom) & ~md_r, 1'($urandom), 1'($urandom));
         cyc("reset_hold", E_ZERO);
      end
      reset = 1'b1;
      idle();
      cyc("post_reset", E_ALL);

      // Single-cycle RUN table (includes a short dmem wait through MEM_WAIT)
      tbl.push_back(mkv("idle",       5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, E_ALL));
      tbl.push_back(mkv("lu_rs2",     5'd0, 5'd5, 0, 1, 5'd5, 1, 0, 0, 1, E_LU));
      tbl.push_back(mkv("lu_rs1",     5'd7, 5'd3, 1, 1, 5'd7, 1, 0, 0, 1, E_LU));
      tbl.push_back(mkv("lu_rd0",     5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, 1, E_ALL));
      tbl.push_back(mkv("lu_unused",  5'd9, 5'd9, 0, 0, 5'd9, 1, 0, 0, 1, E_ALL));
      tbl.push_back(mkv("lu_noload",  5'd5, 5'd5, 1, 1, 5'd5, 0, 0, 0, 1, E_ALL));
      tbl.push_back(mkv("lu_differ",  5'd4, 5'd6, 1, 1, 5'd5, 1, 0, 0, 1, E_ALL));
      tbl.push_back(mkv("branch",     5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 1, E_BR));
      tbl.push_back(mkv("branch_lu",  5'd0, 5'd5, 0, 1, 5'd5, 1, 1, 0, 1, E_BR));
      tbl.push_back(mkv("stall_run",  5'd0, 5'd5, 0, 1, 5'd5, 1, 1, 1, 0, E_ZERO));
      tbl.push_back(mkv("stall_wait", 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, E_ZERO | 11'd1));
      tbl.push_back(mkv("wait_lu",    5'd8, 5'd0, 1, 0, 5'd8, 1, 0, 1, 1, E_LU | 11'd1));
      tbl.push_back(mkv("back_run",   5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, E_ALL));
      foreach (tbl[i]) begin
         drive(tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].rd,
               tbl[i].mr, tbl[i].md, tbl[i].br, tbl[i].req, tbl[i].rdy);
         cyc(tbl[i].name, tbl[i].exp);
      end

      // Mul/div, MD_LATENCY=8: entry + 6 holds, then release
      idle();
      md_entry();
      for (int i = 0; i < 6; i++) begin
         if (i == 2) drive(5'd0, 5'd5, 0, 1, 5'd5, 1, 0, 1, 0, 1);
         else        idle();
         cyc("md_hold", E_HOLD);
      end
      idle();
      cyc("md_release", E_REL);
      cyc("md_after", E_ALL);

      // dmem wait inside MD_BUSY starting at md_cnt=2
      md_entry();
      for (int i = 0; i < 4; i++) cyc("md_hold2", E_HOLD);
      drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 4; i++) cyc("md_memstall", E_MDST);
      drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 1);
      cyc("md_mem_release", E_REL);
      idle();
      cyc("md_mem_after", E_ALL);

      // Reset in MD_BUSY
      md_entry();
      cyc("md_hold3", E_HOLD);
      cyc("md_hold3", E_HOLD);
      reset = 1'b0;
      cyc("rst_in_md", E_ZERO);
      reset = 1'b1;
      cyc("rst_md_after", E_ALL);
      md_entry();
      for (int i = 0; i < 6; i++) cyc("md_hold4", E_HOLD);
      cyc("md_release4", E_REL);

      // Reset in MEM_WAIT
      drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0);
      cyc("stall_a", E_ZERO);
      cyc("stall_b", mk(5'b00000, 3'b000, 1'b0, 2'd1));
      reset = 1'b0;
      cyc("rst_in_wait", E_ZERO);
      reset = 1'b1;
      idle();
      cyc("rst_wait_after", E_ALL);
      cyc("run_idle", E_ALL);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
